sdpram_fifo_ctrl: RTL and testbench
===================================

Name: sdpram_fifo_ctrl

Overview:
FIFO controller that wraps the simple dual-port RAM (one write port, one read port) and turns it into a streaming valid/ready FIFO. It sits directly upstream of the RAM. It drives dina/addra/wena from a push stream and addrb/renb from a pop stream. It absorbs the RAM's 1-cycle registered read latency with a 2-entry output buffer, so the FIFO sustains one word per cycle in and out.

Parameters:
DATA_WIDTH, 32, word width; matches RAM data width
DEPTH, 1024, RAM entries; must be a power of 2
ADDR_WIDTH, $clog2(DEPTH) = 10, RAM address width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
in_valid  in  1  push request
in_data  in  DATA_WIDTH  push data
in_ready  out  1  push accepted when in_valid & in_ready
out_valid  out  1  head word available
out_data  out  DATA_WIDTH  head word
out_ready  in  1  pop when out_valid & out_ready
ram_dina  out  DATA_WIDTH  to RAM dina
ram_addra  out  ADDR_WIDTH  to RAM addra
ram_wena  out  1  to RAM wena
ram_addrb  out  ADDR_WIDTH  to RAM addrb
ram_renb  out  1  to RAM renb
ram_doutb  in  DATA_WIDTH  RAM read data; valid the cycle after ram_renb=1
level  out  ADDR_WIDTH+1  total words held (RAM + in-flight + buffer), max DEPTH+2

Behaviour:
- Reset (rst=0, async): wr_ptr, rd_ptr, ram_count, buffer count and in-flight flag all clear. While reset is asserted, out_valid=0, out_data=0, level=0, ram_wena=0 and ram_renb=0. in_ready goes to 1 from the first cycle after release.
- Reset mid-operation discards all contents. No RAM write or read is issued during reset.
- Write side (combinational):
  - in_ready = (ram_count < DEPTH).
  - ram_wena = in_valid & in_ready; ram_addra = wr_ptr; ram_dina = in_data.
  - wr_ptr increments modulo DEPTH on each accepted push. ADDR_WIDTH bits, so wrap is natural.
- ram_count tracks words resident in the RAM. It is registered: +1 on push, -1 on read issue; simultaneous push and issue leaves it unchanged.
- Read issue (combinational):
  - ram_renb = (ram_count > 0) & (buf_count + inflight - pop < 2), where pop = out_valid & out_ready.
  - ram_addrb = rd_ptr; rd_ptr increments modulo DEPTH on issue.
  - inflight <= ram_renb (registered).
  - A read never targets the address being written in the same cycle, because ram_count reflects only pushes from prior cycles.
- Output buffer:
  - 2 entries, FIFO-ordered.
  - When inflight=1, ram_doutb is captured at that clock edge.
  - out_valid = (buf_count > 0); out_data = head entry, registered. Capture and pop in the same cycle are both honoured.
  - out_data holds its value while out_valid=1 and out_ready=0.
  - The buffer never overflows: guaranteed by the issue condition.
- Latency: a push accepted in cycle 0 gives ram_renb in cycle 1, RAM data in cycle 2, and out_valid=1 in cycle 3 (empty FIFO). Sustained throughput is 1 word/cycle once primed.
- Full: when ram_count = DEPTH, in_ready=0. A pop that triggers a read issue frees a slot; in_ready rises the cycle after the issue.
- Empty: when level=0, out_valid=0 and ram_renb=0; an out_ready-only cycle has no effect.
- level = ram_count + inflight + buf_count, registered.

Test Plan:
- Single word: after reset, push 32'h55 for one cycle with out_ready=1 -> ram_wena=1 and ram_addra=0 in cycle 0; ram_renb=1 and ram_addrb=0 in cycle 1; out_valid=1 with out_data=32'h55 in cycle 3; level returns to 0.
- Streaming: push 0..99 back-to-back with out_ready=1 -> outputs 0..99 in order, one per cycle from cycle 3, no bubbles.
- Full: out_ready=0, push continuously -> 1026 words accepted (1024 in RAM plus 2 buffered); in_ready=0 once ram_count=1024, with level=1026. One pop brings in_ready back to 1 within 2 cycles.
- Backpressure: stream data while toggling out_ready pseudo-randomly -> no loss or duplication; out_data stable while stalled.
- Wrap-around: push/pop 3000 words with partial occupancy -> ram_addra and ram_addrb wrap 1023->0; data order preserved.
- Reset mid-op: hold 500 words, then pulse rst=0 asynchronously between edges -> out_valid, level and ram_renb drop immediately; after release in_ready=1, and the next push of 32'hA5 returns as the first output.

Source files
------------

// File: rtl/sdpram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sdpram_fifo_ctrl
// Brief    : Streaming valid/ready FIFO built around a simple dual-port RAM,
//            hiding the RAM's 1-cycle read latency behind a 2-entry buffer.
// Revision : 1.0 - initial release
// ============================================================================
module sdpram_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic                  ram_wena,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  output logic                  ram_renb,
  input  logic [DATA_WIDTH-1:0] ram_doutb,
  output logic [ADDR_WIDTH:0]   level
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_W-1:0]      ram_count;
  logic [CNT_W-1:0]      ram_count_nxt;
  logic [CNT_W-1:0]      level_nxt;
  logic                  inflight;
  logic [1:0]            buf_count;
  logic [1:0]            buf_count_nxt;
  logic [DATA_WIDTH-1:0] buf0;
  logic [DATA_WIDTH-1:0] buf1;
  logic                  push;
  logic                  pop;
  logic                  issue;
  logic [2:0]            buf_demand;
  logic [2:0]            buf_room;

  // Handshakes are gated by rst so nothing reaches the RAM while held in reset.
  assign in_ready  = rst & (ram_count < DEPTH_C);
  assign push      = in_valid & in_ready;
  assign out_valid = (buf_count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_data  = buf0;

  assign ram_wena  = push;
  assign ram_addra = wr_ptr;
  assign ram_dina  = in_data;

  // buf_count + inflight - pop < 2, rearranged to stay unsigned.
  assign buf_demand = {1'b0, buf_count} + {2'b00, inflight};
  assign buf_room   = 3'd2 + {2'b00, pop};
  assign issue      = rst & (ram_count != '0) & (buf_demand < buf_room);
  assign ram_renb   = issue;
  assign ram_addrb  = rd_ptr;

  always_comb begin
    ram_count_nxt = ram_count;
    case ({push, issue})
      2'b10:   ram_count_nxt = ram_count + ONE_C;
      2'b01:   ram_count_nxt = ram_count - ONE_C;
      default: ram_count_nxt = ram_count;
    endcase

    buf_count_nxt = buf_count;
    case ({inflight, pop})
      2'b10:   buf_count_nxt = buf_count + 2'd1;
      2'b01:   buf_count_nxt = buf_count - 2'd1;
      default: buf_count_nxt = buf_count;
    endcase

    level_nxt = ram_count_nxt + CNT_W'(issue) + CNT_W'(buf_count_nxt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_count <= '0;
      inflight  <= 1'b0;
      buf_count <= 2'd0;
      level     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      ram_count <= ram_count_nxt;
      inflight  <= issue;
      buf_count <= buf_count_nxt;
      level     <= level_nxt;
    end
  end

  // buf0 is the head; buf1 only matters when two words are held, so it can
  // take every returning word unconditionally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      if (inflight && ((buf_count == 2'd0) || ((buf_count == 2'd1) && pop))) begin
        buf0 <= ram_doutb;
      end else if (pop) begin
        buf0 <= buf1;
      end
      if (inflight) buf1 <= ram_doutb;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdpram_fifo_ctrl.sv
`default_nettype none
// Testbench for sdpram_fifo_ctrl: behavioural RAM, queue scoreboard,
// a per-cycle vector table and directed multi-cycle sequences.
module tb_sdpram_fifo_ctrl;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic [DW-1:0] ram_dina;
  logic [AW-1:0] ram_addra;
  logic          ram_wena;
  logic [AW-1:0] ram_addrb;
  logic          ram_renb;
  logic [DW-1:0] ram_doutb;
  logic [AW:0]   level;

  always #5 clk = ~clk;

  sdpram_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .ram_dina(ram_dina), .ram_addra(ram_addra), .ram_wena(ram_wena),
    .ram_addrb(ram_addrb), .ram_renb(ram_renb), .ram_doutb(ram_doutb),
    .level(level)
  );

  // Simple dual-port RAM with registered read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wena) mem[ram_addra] <= ram_dina;
    if (ram_renb) ram_doutb <= mem[ram_addrb];
  end

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] sb [$];
  int            acc_count = 0;
  logic [AW-1:0] exp_wa = '0;
  logic [AW-1:0] exp_ra = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: level lags the handshakes by one edge, so it must
  // match the queue depth before this cycle's push/pop is applied.
  always @(negedge clk) begin
    if (rst) begin
      check("level_vs_model", level, sb.size());
      if (out_valid) begin
        if (sb.size() == 0) check("out_valid_when_empty", out_valid, 1'b0);
        else                check("out_data_head", out_data, sb[0]);
      end
      if (ram_wena) begin check("ram_addra", ram_addra, exp_wa); exp_wa++; end
      if (ram_renb) begin check("ram_addrb", ram_addrb, exp_ra); exp_ra++; end
      if (in_valid && in_ready) begin sb.push_back(in_data); acc_count++; end
      if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
    end
  end

  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || level != 0) && n < 4000) begin
      drive(1'b0, '0, 1'b1);
      @(negedge clk);
      n++;
    end
    check(name, sb.size(), 0);
    drive(1'b0, '0, 1'b0);
  endtask

  typedef struct {
    logic          iv;
    logic [DW-1:0] id;
    logic          ordy;
    logic          e_wena;
    logic [AW-1:0] e_addra;
    logic          e_renb;
    logic [AW-1:0] e_addrb;
    logic          e_ovalid;
    logic [DW-1:0] e_odata;
    logic [AW:0]   e_level;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int first, last, npop, base, ok;
    logic [DW-1:0] dcnt;

    // Single-word latency trace, one record per cycle from the push cycle.
    vecs[0] = '{1'b1, 32'h55, 1'b1, 1'b1, 10'd0, 1'b0, 10'd0, 1'b0, 32'h0,  11'd0};
    vecs[1] = '{1'b0, 32'h0,  1'b1, 1'b0, 10'd1, 1'b1, 10'd0, 1'b0, 32'h0,  11'd1};
    vecs[2] = '{1'b0, 32'h0,  1'b1, 1'b0, 10'd1, 1'b0, 10'd1, 1'b0, 32'h0,  11'd1};
    vecs[3] = '{1'b0, 32'h0,  1'b1, 1'b0, 10'd1, 1'b0, 10'd1, 1'b1, 32'h55, 11'd1};
    vecs[4] = '{1'b0, 32'h0,  1'b1, 1'b0, 10'd1, 1'b0, 10'd1, 1'b0, 32'h0,  11'd0};

    // Reset state, with a push request held to show nothing leaks through.
    in_valid = 1'b1;
    in_data  = 32'hDEAD;
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_level", level, 0);
    check("rst_wena", ram_wena, 1'b0);
    check("rst_renb", ram_renb, 1'b0);
    in_valid = 1'b0;
    #14 rst = 1'b1;
    @(negedge clk);
    check("in_ready_after_release", in_ready, 1'b1);

    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].iv, vecs[i].id, vecs[i].ordy);
      @(negedge clk);
      check($sformatf("vec%0d_wena", i),   ram_wena,  vecs[i].e_wena);
      check($sformatf("vec%0d_addra", i),  ram_addra, vecs[i].e_addra);
      check($sformatf("vec%0d_renb", i),   ram_renb,  vecs[i].e_renb);
      check($sformatf("vec%0d_addrb", i),  ram_addrb, vecs[i].e_addrb);
      check($sformatf("vec%0d_ovalid", i), out_valid, vecs[i].e_ovalid);
      if (vecs[i].e_ovalid) check($sformatf("vec%0d_odata", i), out_data, vecs[i].e_odata);
      check($sformatf("vec%0d_level", i),  level,     vecs[i].e_level);
    end

    // Streaming 0..99 with out_ready=1: first output at cycle 3, no bubbles.
    first = -1; last = -1; npop = 0;
    for (int k = 0; k < 115; k++) begin
      drive(k < 100, DW'(k), 1'b1);
      @(negedge clk);
      if (out_valid && first < 0) first = k;
      if (out_valid && out_ready) begin
        npop++;
        if (npop == 100) last = k;
      end
    end
    check("stream_first_cycle", first, 3);
    check("stream_last_cycle", last, 102);
    drain("stream_drain");

    // Backpressure with random valid/ready.
    dcnt = 32'h1000;
    for (int k = 0; k < 400; k++) begin
      drive(($urandom % 4) != 0, dcnt, $urandom % 2);
      dcnt++;
    end
    drain("backpressure_drain");

    // Full: 1024 in RAM plus 2 in the output buffer.
    base = acc_count;
    for (int k = 0; k < 1100; k++) begin
      drive(1'b1, dcnt, 1'b0);
      dcnt++;
    end
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    check("full_accepted", acc_count - base, 1026);
    check("full_level", level, 1026);
    check("full_in_ready", in_ready, 1'b0);
    drive(1'b0, '0, 1'b1);
    ok = 0;
    for (int w = 0; w < 2 && ok == 0; w++) begin
      drive(1'b0, '0, 1'b0);
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    check("in_ready_after_pop", ok, 1);
    drain("full_drain");

    // Wrap-around with partial occupancy; address model checks the wrap.
    base = acc_count;
    for (int k = 0; k < 4500; k++) begin
      drive(($urandom % 4) != 0, $urandom, ($urandom % 4) != 0);
    end
    drain("wrap_drain");
    check("wrap_pushes_exceed_2x_depth", (acc_count - base) > 2 * DEPTH, 1'b1);

    // Reset mid-operation while reads are being issued.
    for (int k = 0; k < 500; k++) begin
      drive(1'b1, dcnt, 1'b0);
      dcnt++;
    end
    drive(1'b0, '0, 1'b1);
    @(negedge clk);
    check("pre_reset_renb", ram_renb, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_level", level, 0);
    check("midrst_renb", ram_renb, 1'b0);
    out_ready = 1'b0;
    sb.delete();
    exp_wa = '0;
    exp_ra = '0;
    @(posedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready_after", in_ready, 1'b1);
    drive(1'b1, 32'hA5, 1'b1);
    ok = 0;
    for (int w = 0; w < 10 && ok == 0; w++) begin
      drive(1'b0, '0, 1'b1);
      @(negedge clk);
      if (out_valid) begin
        ok = 1;
        check("midrst_first_out", out_data, 32'hA5);
      end
    end
    check("midrst_output_seen", ok, 1);
    drain("final_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
